// File: rtl/acc_requant_collector_if.sv
// Output row bus between the requant collector and the output writer.
interface acc_requant_collector_if #(
   parameter int unsigned SIZE = 16
);
   logic              out_valid_o;
   logic              out_ready_i;
   logic [SIZE*8-1:0] out_data_o;
   logic [SIZE-1:0]   out_mask_o;

   modport master (output out_valid_o, output out_data_o, output out_mask_o, input out_ready_i);
   modport slave  (input out_valid_o, input out_data_o, input out_mask_o, output out_ready_i);
endinterface

// File: rtl/acc_requant_collector.sv
// Collects skewed accumulator lanes into a row, requantizes each lane to int8
// through a 3-stage serial pipeline and hands the packed row to the writer.
module acc_requant_collector #(
   parameter int unsigned SIZE       = 16,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [SIZE-1:0][DATA_WIDTH-1:0]  acc_data_i,
   input  logic [SIZE-1:0]                  acc_valid_i,
   input  logic [$clog2(SIZE):0]            lane_cnt_i,
   input  logic                             tile_over_i,
   input  logic signed [31:0]               bias_i,
   input  logic signed [31:0]               mult_i,
   input  logic signed [5:0]                shift_i,
   input  logic signed [7:0]                out_zp_i,
   input  logic signed [7:0]                act_min_i,
   input  logic signed [7:0]                act_max_i,
   acc_requant_collector_if.master          out_bus,
   output logic                             busy_o,
   output logic                             tile_done_o,
   output logic                             overflow_o
);
   localparam int unsigned LC_W  = $clog2(SIZE) + 1;
   localparam int unsigned IDX_W = $clog2(SIZE);
   localparam int unsigned CNT_W = $clog2(SIZE + 3) + 1;

   typedef enum logic [1:0] {COLLECT, REQ, OUT} state_t;

   state_t                           state, state_next;
   logic [SIZE-1:0]                  captured, cap_next, lane_mask, strobe_hit;
   logic [SIZE-1:0][DATA_WIDTH-1:0]  acc_buf;
   logic [SIZE-1:0][7:0]             slots;
   logic                             pending_tile, tile_clear, ovf_event, row_start;
   logic [CNT_W-1:0]                 cnt;
   logic [IDX_W-1:0]                 lane_idx;
   logic                             issue;

   logic [4:0]                       sh_l, sh_r;
   logic signed [31:0]               x, xl;
   logic                             s1_v, s2_v;
   logic [IDX_W-1:0]                 s1_idx, s2_idx;
   logic signed [31:0]               s1_xl, s2_hi, hi;
   logic [63:0]                      prod, nudge, rsum, radj;
   logic signed [63:0]               rq;
   logic [31:0]                      rmask, rem, thr, zp_ext;
   logic signed [31:0]               hi_sh, y, lo_ext, up_ext, yc;

   assign out_bus.out_data_o = slots;

   // Active-lane mask derived from the live lane count.
   always_comb begin
      for (int i = 0; i < SIZE; i++) lane_mask[i] = (LC_W'(i) < lane_cnt_i);
   end

   // Next-state logic plus capture bookkeeping.
   always_comb begin
      state_next = state;
      strobe_hit = acc_valid_i & lane_mask;
      cap_next   = captured;
      tile_clear = (state == COLLECT) && (captured == '0) && pending_tile;
      ovf_event  = |strobe_hit;
      case (state)
         COLLECT: begin
            cap_next  = captured | strobe_hit;
            ovf_event = |(strobe_hit & captured);
            if ((cap_next == lane_mask) || (tile_over_i && (cap_next != '0)))
               state_next = REQ;
         end
         REQ: begin
            if (cnt == CNT_W'(lane_cnt_i) + CNT_W'(2)) state_next = OUT;
         end
         OUT: begin
            if (out_bus.out_ready_i) begin
               state_next = COLLECT;
               cap_next   = '0;
            end
         end
         default: state_next = COLLECT;
      endcase
      row_start = (state == COLLECT) && (state_next == REQ);
   end

   // FSM state, control flags and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= COLLECT;
         captured            <= '0;
         pending_tile        <= 1'b0;
         cnt                 <= '0;
         out_bus.out_valid_o <= 1'b0;
         out_bus.out_mask_o  <= '0;
         busy_o              <= 1'b0;
         tile_done_o         <= 1'b0;
         overflow_o          <= 1'b0;
      end else begin
         state               <= state_next;
         captured            <= cap_next;
         pending_tile        <= tile_over_i | (pending_tile & ~tile_clear);
         tile_done_o         <= tile_clear;
         cnt                 <= (state == REQ) ? cnt + CNT_W'(1) : '0;
         out_bus.out_valid_o <= (state_next == OUT);
         busy_o              <= (state_next != COLLECT);
         if (ovf_event) overflow_o <= 1'b1;
         if (row_start) out_bus.out_mask_o <= lane_mask;
      end
   end

   // Row buffer: first strobe per lane wins.
   always_ff @(posedge clk) begin
      for (int i = 0; i < SIZE; i++)
         if (state == COLLECT && strobe_hit[i] && !captured[i]) acc_buf[i] <= acc_data_i[i];
   end

   // Stage 1 operands: bias add and left shift of the issued lane.
   always_comb begin
      sh_l     = (shift_i > 0) ? shift_i[4:0] : 5'd0;
      sh_r     = (shift_i < 0) ? 5'(-shift_i) : 5'd0;
      lane_idx = cnt[IDX_W-1:0];
      issue    = (state == REQ) && (cnt < CNT_W'(lane_cnt_i));
      x        = (captured[lane_idx] ? acc_buf[lane_idx] : '0) + bias_i;
      xl       = x << sh_l;
   end

   // Stage 2 operands: rounding doubling high multiply.
   always_comb begin
      prod  = {{32{s1_xl[31]}}, s1_xl} * {{32{mult_i[31]}}, mult_i};
      nudge = prod[63] ? 64'hFFFF_FFFF_C000_0001 : 64'h0000_0000_4000_0000;
      rsum  = prod + nudge;
      radj  = rsum + (rsum[63] ? 64'h0000_0000_7FFF_FFFF : 64'd0);
      rq    = $signed(radj) >>> 31;
      if (s1_xl == 32'h8000_0000 && mult_i == 32'h8000_0000) hi = 32'h7FFF_FFFF;
      else                                                    hi = rq[31:0];
   end

   // Stage 3 operands: rounding right shift, zero point and clamp.
   always_comb begin
      rmask  = (32'd1 << sh_r) - 32'd1;
      rem    = s2_hi & rmask;
      thr    = (rmask >> 1) + {31'd0, s2_hi[31]};
      hi_sh  = s2_hi >>> sh_r;
      zp_ext = {{24{out_zp_i[7]}}, out_zp_i};
      y      = hi_sh + {31'd0, (rem > thr)} + zp_ext;
      lo_ext = {{24{act_min_i[7]}}, act_min_i};
      up_ext = {{24{act_max_i[7]}}, act_max_i};
      if (y < lo_ext)      yc = lo_ext;
      else if (y > up_ext) yc = up_ext;
      else                 yc = y;
   end

   // Pipeline registers and output lane slots.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v   <= 1'b0;
         s2_v   <= 1'b0;
         s1_idx <= '0;
         s2_idx <= '0;
         s1_xl  <= '0;
         s2_hi  <= '0;
         slots  <= '0;
      end else begin
         s1_v   <= issue;
         s1_idx <= lane_idx;
         s1_xl  <= xl;
         s2_v   <= s1_v;
         s2_idx <= s1_idx;
         s2_hi  <= hi;
         if (row_start)  slots <= '0;
         else if (s2_v)  slots[s2_idx] <= yc[7:0];
      end
   end
endmodule

// File: tb/tb_acc_requant_collector.sv
// Directed bench for acc_requant_collector with SIZE=4.
module tb_acc_requant_collector;
   localparam int unsigned SIZE = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [SIZE-1:0][31:0] acc_data;
   logic [SIZE-1:0]       acc_valid;
   logic [2:0]            lane_cnt;
   logic                  tile_over;
   logic [31:0]           bias, mult;
   logic [5:0]            shift;
   logic [7:0]            zp, amin, amax;
   logic                  busy, tile_done, overflow;
   logic                  seen;
   int                    checks = 0;
   int                    errors = 0;

   always #5 clk = ~clk;

   acc_requant_collector_if #(.SIZE(SIZE)) bus ();

   acc_requant_collector #(.SIZE(SIZE), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .acc_data_i (acc_data),
      .acc_valid_i(acc_valid),
      .lane_cnt_i (lane_cnt),
      .tile_over_i(tile_over),
      .bias_i     (bias),
      .mult_i     (mult),
      .shift_i    (shift),
      .out_zp_i   (zp),
      .act_min_i  (amin),
      .act_max_i  (amax),
      .out_bus    (bus),
      .busy_o     (busy),
      .tile_done_o(tile_done),
      .overflow_o (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!bus.out_valid_o && n < budget) begin
         tick();
         n++;
      end
      check("valid_timeout", 32'(bus.out_valid_o), 32'd1);
   endtask

   task automatic handshake();
      bus.out_ready_i = 1'b1;
      tick();
      bus.out_ready_i = 1'b0;
      check("hs_valid_drop", 32'(bus.out_valid_o), 32'd0);
      check("hs_idle", 32'(busy), 32'd0);
   endtask

   task automatic full_row(input string tag, input logic [31:0] exp);
      acc_valid = 4'hF;
      tick();
      acc_valid = 4'h0;
      wait_valid(20);
      check(tag, bus.out_data_o, exp);
      check("row_mask", 32'(bus.out_mask_o), 32'hF);
      handshake();
   endtask

   initial begin
      rst = 1'b1; acc_data = '0; acc_valid = '0; lane_cnt = 3'd4; tile_over = 1'b0;
      bias = 32'd0; mult = 32'h4000_0000; shift = 6'd0; zp = 8'd0;
      amin = 8'h80; amax = 8'h7F; bus.out_ready_i = 1'b0;
      tick(); tick();
      check("rst_valid", 32'(bus.out_valid_o), 32'd0);
      check("rst_data", bus.out_data_o, 32'd0);
      check("rst_mask", 32'(bus.out_mask_o), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(tile_done), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;

      // skewed strobes, one lane per cycle
      acc_data[0] = 32'd100; acc_data[1] = -32'sd101; acc_data[2] = 32'd0; acc_data[3] = 32'd1000;
      for (int i = 0; i < 4; i++) begin
         acc_valid = 4'b0001 << i;
         tick();
      end
      acc_valid = 4'h0;
      check("busy_after_row", 32'(busy), 32'd1);
      repeat (6) tick();
      check("valid_not_early", 32'(bus.out_valid_o), 32'd0);
      tick();
      check("valid_on_time", 32'(bus.out_valid_o), 32'd1);
      check("row1_data", bus.out_data_o, 32'h7F00_CE32);
      check("row1_mask", 32'(bus.out_mask_o), 32'hF);
      check("row1_ovf", 32'(overflow), 32'd0);
      tick();
      check("row1_hold", 32'(bus.out_valid_o), 32'd1);
      handshake();

      // right shift with zero point
      shift = 6'h3F; zp = 8'd3;
      for (int i = 0; i < 4; i++) acc_data[i] = -32'sd101;
      full_row("shr_zp", 32'hEAEA_EAEA);

      // left shift
      shift = 6'h01; zp = 8'd0;
      acc_data[0] = 32'd100; acc_data[1] = -32'sd1; acc_data[2] = 32'd0; acc_data[3] = 32'd64;
      full_row("shl", 32'h4000_FF64);

      // bias, negative zero point, raised lower clamp
      shift = 6'd0; bias = 32'd50; zp = 8'hFB; amin = 8'hEC;
      acc_data[0] = 32'd50; acc_data[1] = -32'sd150; acc_data[2] = -32'sd50; acc_data[3] = -32'sd50;
      full_row("bias_clamp_lo", 32'hFBFB_EC2D);

      // saturating multiply, clamped at 127 then at 50
      bias = 32'd0; zp = 8'd0; amin = 8'h80; mult = 32'h8000_0000; shift = 6'h28;
      acc_data = '0; acc_data[0] = 32'h8000_0000;
      full_row("sat_127", 32'h0000_007F);
      amax = 8'd50;
      full_row("sat_50", 32'h0000_0032);

      // partial lane count with strobes on every lane
      mult = 32'h4000_0000; shift = 6'd0; amax = 8'h7F; lane_cnt = 3'd2;
      acc_data[0] = 32'd100; acc_data[1] = -32'sd101; acc_data[2] = 32'd7; acc_data[3] = 32'd7;
      acc_valid = 4'hF;
      tick();
      acc_valid = 4'h0;
      repeat (4) tick();
      check("lc2_not_early", 32'(bus.out_valid_o), 32'd0);
      tick();
      check("lc2_on_time", 32'(bus.out_valid_o), 32'd1);
      check("lc2_data", bus.out_data_o, 32'h0000_CE32);
      check("lc2_mask", 32'(bus.out_mask_o), 32'h3);
      check("lc2_ovf", 32'(overflow), 32'd0);

      // backpressure with a strobe injected while busy
      acc_data[0] = 32'd20;
      for (int k = 0; k < 10; k++) begin
         acc_valid = (k == 3) ? 4'b0001 : 4'b0000;
         tick();
         check("bp_data", bus.out_data_o, 32'h0000_CE32);
      end
      acc_valid = 4'h0;
      check("bp_valid", 32'(bus.out_valid_o), 32'd1);
      check("bp_ovf", 32'(overflow), 32'd1);
      handshake();

      // lane0 strobe must have been dropped: only lane1 captured, then tile_over
      acc_data[1] = 32'd8;
      acc_valid = 4'b0010;
      tick();
      acc_valid = 4'h0; tile_over = 1'b1;
      tick();
      tile_over = 1'b0;
      wait_valid(20);
      check("drop_data", bus.out_data_o, 32'h0000_0400);
      check("drop_mask", 32'(bus.out_mask_o), 32'h3);
      handshake();
      repeat (3) tick();

      // tile_over with only lane0 captured, then end-of-tile pulse
      rst = 1'b1;
      tick();
      check("rst2_ovf", 32'(overflow), 32'd0);
      rst = 1'b0; lane_cnt = 3'd4;
      acc_data[0] = 32'd8;
      acc_valid = 4'b0001;
      tick();
      acc_valid = 4'h0; tile_over = 1'b1;
      tick();
      tile_over = 1'b0;
      wait_valid(20);
      check("tile_data", bus.out_data_o, 32'h0000_0004);
      check("tile_mask", 32'(bus.out_mask_o), 32'hF);
      handshake();
      check("tile_done_pre", 32'(tile_done), 32'd0);
      tick();
      check("tile_done_pulse", 32'(tile_done), 32'd1);
      tick();
      check("tile_done_post", 32'(tile_done), 32'd0);

      // reset during REQ discards the row
      acc_valid = 4'hF;
      tick();
      acc_valid = 4'h0;
      tick(); tick();
      check("mid_req_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      check("mrst_valid", 32'(bus.out_valid_o), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_data", bus.out_data_o, 32'd0);
      check("mrst_mask", 32'(bus.out_mask_o), 32'd0);
      check("mrst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         tick();
         if (bus.out_valid_o) seen = 1'b1;
      end
      check("mrst_no_row", 32'(seen), 32'd0);
      check("mrst_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/acc_requant_collector.md
Name: acc_requant_collector

Overview:
- Sits directly downstream of the shift-accumulator array.
- Captures the skewed per-column 32-bit accumulator results into a row buffer.
- Requantizes each lane to int8 with TFLM per-tensor semantics (bias, quantized multiplier, shift, zero point, activation clamp).
- Emits one packed int8 row per valid/ready handshake and signals end-of-tile to the output writer.

Parameters:
- SIZE, 16, number of accumulator lanes (columns).
- DATA_WIDTH, 32, accumulator width; must be 32.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- acc_data_i  in  SIZE x DATA_WIDTH  per-lane accumulator results.
- acc_valid_i  in  SIZE  per-lane capture strobe (strobes arrive skewed in time).
- lane_cnt_i  in  $clog2(SIZE)+1  active lanes, 1..SIZE; lanes >= lane_cnt_i are ignored.
- tile_over_i  in  1  one-cycle pulse: accumulator tile finished.
- bias_i  in  32  signed per-tensor bias.
- mult_i  in  32  signed quantized multiplier.
- shift_i  in  6  signed shift; >0 is left, <=0 is right; legal range -31..+30.
- out_zp_i  in  8  signed output zero point.
- act_min_i, act_max_i  in  8 each  signed clamp bounds; act_min_i <= act_max_i.
- out_valid_o  out  1  packed row valid.
- out_ready_i  in  1  consumer accepts the row.
- out_data_o  out  SIZE x 8  int8 row; lane i occupies bits [8i+7:8i].
- out_mask_o  out  SIZE  active-lane mask of the row.
- busy_o  out  1  FSM not in COLLECT.
- tile_done_o  out  1  one-cycle end-of-tile pulse.
- overflow_o  out  1  sticky capture error.

Behaviour:
- Reset values: all outputs 0; FSM in COLLECT; captured mask 0; pending_tile 0. Reset mid-row discards all partial and in-flight data.
- FSM states: COLLECT -> REQ -> OUT -> COLLECT.
- COLLECT:
  - A lane i < lane_cnt_i with acc_valid_i[i]=1 stores acc_data_i[i] and sets captured[i].
  - A strobe on an already-captured lane keeps the first value and sets overflow_o.
  - When captured == mask(lane_cnt_i), the state moves to REQ on the next cycle. A strobe that completes the row takes effect on that same edge.
- tile_over_i sets pending_tile.
  - In COLLECT with captured == 0 and pending_tile=1: pulse tile_done_o for one cycle and clear pending_tile.
  - tile_over_i arriving with a partial row forces REQ; uncaptured lanes are processed as 0 and out_mask_o still equals mask(lane_cnt_i).
- Any acc_valid_i strobe while busy_o=1 is dropped and sets overflow_o. overflow_o clears only on rst.
- REQ: lanes are issued serially, one per cycle, index 0..lane_cnt_i-1, into a 3-stage pipeline. The row finishes lane_cnt_i+3 cycles after REQ entry, then the state moves to OUT. Inactive lanes output 0.
- Quant inputs and lane_cnt_i must be held stable while busy_o=1; they are not latched.
- Per-lane arithmetic, all 32-bit two's complement with wrap unless stated:
  - S1: x = acc + bias. l = max(shift,0), r = max(-shift,0). xl = x << l, wrapped.
  - S2: if xl == mult == INT32_MIN, then hi = INT32_MAX. Otherwise p = xl*mult as 64-bit signed; nudge = p >= 0 ? 2^30 : 1-2^30; hi = (p+nudge)/2^31, truncated toward zero.
  - S3: mask = 2^r-1; rem = hi & mask; thr = (mask>>1) + (hi<0); y = (hi >>> r) + (rem > thr) + out_zp; clamp y to [act_min, act_max]; store to lane slot.
- OUT: out_valid_o=1 with data and mask held stable until out_ready_i=1. On the handshake edge: out_valid_o drops, captured clears, and the state returns to COLLECT. There is no combinational path from out_ready_i to any output.
- Back-to-back rows: the earliest next-row capture is the cycle after the handshake.

Test Plan:
- SIZE=4, lane_cnt=4, skewed strobes lane0..3 on cycles 0..3, acc={100,-101,0,1000}, bias=0, mult=0x40000000, shift=0, zp=0, clamp [-128,127] -> out_data={50,-50,0,127}, out_mask=0xF, valid at cycle 4+7.
- acc=-101, mult=0x40000000, shift=-1, zp=3 -> lane out -22. With shift=+1 and acc=100 -> 100.
- acc=INT32_MIN, bias=0, mult=0x80000000, shift=-24 -> hi=INT32_MAX, result 128, clamped to 127. Then act_max=50 -> 50.
- lane_cnt=2, strobes on lanes 0..3 -> lanes 2 and 3 ignored, out_mask=0x3, upper bytes 0, overflow_o stays 0.
- out_ready_i held low 10 cycles with a strobe injected -> data stable, overflow_o=1, strobe dropped. Ready then high -> one transfer, back to COLLECT.
- tile_over_i after lane0 only captured (acc=8, mult=0x40000000) -> row {4,0,0,0} emitted, then tile_done_o pulses once. rst asserted mid-REQ -> all outputs 0 and no row emitted.
